// File: rtl/etx_pkg.sv
// etx_pkg: shared types, constants and helpers for the eLink transmit serializer.
//   state_t       serializer FSM encoding (IDLE, HDR, PAY, GAP)
//   emesh_t       decoded emesh packet fields
//   HDR_W/PAY_W   header and payload word widths
//   beat_counts() header/payload cycle counts for a link width
//   hdr_word()    builds the 48-bit header word from a decoded packet
//   burstable()   decides whether a new packet can extend the current frame
package etx_pkg;

  localparam int HDR_W = 48;
  localparam int PAY_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  datamode;
    logic [4:0]  ctrlmode;
    logic [31:0] dstaddr;
    logic [31:0] data;
    logic [31:0] srcaddr;
  } emesh_t;

  typedef struct packed {
    logic [3:0] hc;
    logic [3:0] pc;
  } beat_cnt_t;

  // A 16-bit link sends the header zero-extended to 64 bits, so both words take two cycles.
  function automatic beat_cnt_t beat_counts(input int lw);
    beat_cnt_t c;
    case (lw)
      32'd16: begin
        c.hc = 4'd2;
        c.pc = 4'd2;
      end
      default: begin
        c.hc = 4'd3;
        c.pc = 4'd4;
      end
    endcase
    return c;
  endfunction

  // Access is always 1 for a packet that reaches the serializer.
  function automatic logic [HDR_W-1:0] hdr_word(input emesh_t p);
    return {~p.write, 7'd0, p.ctrlmode[3:0], p.dstaddr, p.datamode, p.write, 1'b1};
  endfunction

  // Only sequential 64-bit writes with matching ctrlmode merge; the address
  // comparison wraps naturally at 2^32.
  function automatic logic burstable(input logic en, input emesh_t prev, input emesh_t nxt);
    return en
         & prev.write & (prev.datamode == 2'b11)
         & nxt.write  & (nxt.datamode  == 2'b11)
         & (prev.ctrlmode == nxt.ctrlmode)
         & (nxt.dstaddr == (prev.dstaddr + 32'd8));
  endfunction

endpackage

// File: rtl/etx_serializer_if.sv
// etx_serializer_if: emesh packet handshake between the etx arbiter and the serializer.
//   tx_packet  emesh packet (PW bits)
//   tx_valid   packet valid
//   tx_ready   packet accepted on tx_valid & tx_ready at a rising edge
// master = packet source (arbiter), slave = serializer.
interface etx_serializer_if #(
  parameter int PW = 104
);
  logic [PW-1:0] tx_packet;
  logic          tx_valid;
  logic          tx_ready;

  modport master (output tx_packet, output tx_valid, input tx_ready);
  modport slave  (input tx_packet, input tx_valid, output tx_ready);
endinterface

// File: rtl/etx_serializer_p2e.sv
// packet2emesh: splits a flat 104-bit emesh packet into its fields.
//   packet    in  emesh packet
//   write     out write flag          (bit 0)
//   datamode  out access size         (bits 2:1)
//   ctrlmode  out control mode        (bits 7:3)
//   dstaddr   out destination address (bits 39:8)
//   data      out data word           (bits 71:40)
//   srcaddr   out source address      (bits 103:72)
module packet2emesh #(
  parameter int PW = 104
) (
  input  logic [PW-1:0] packet,
  output logic          write,
  output logic [1:0]    datamode,
  output logic [4:0]    ctrlmode,
  output logic [31:0]   dstaddr,
  output logic [31:0]   data,
  output logic [31:0]   srcaddr
);

  assign write    = packet[0];
  assign datamode = packet[2:1];
  assign ctrlmode = packet[7:3];
  assign dstaddr  = packet[39:8];
  assign data     = packet[71:40];
  assign srcaddr  = packet[103:72];

endmodule

// File: rtl/etx_serializer.sv
// etx_serializer: eLink transmit serializer. Accepts emesh packets, sends a
// header word then a payload word, 2*LW bits per tx_lclk, most-significant
// slice first, with a frame strobe. Sequential 64-bit writes merge into bursts.
//   tx_lclk     in   link clock
//   nreset      in   asynchronous active-low reset
//   tx          if   packet handshake (slave side: tx_packet, tx_valid, tx_ready)
//   tx_wr_wait  in   write pushback (tx_lclk domain)
//   tx_rd_wait  in   read pushback (tx_lclk domain)
//   txo_data    out  beat pair, upper LW bits on the rising edge (registered)
//   txo_frame   out  frame strobe (registered)
//   tx_busy     out  high while the FSM is not IDLE (registered)
module etx_serializer
  import etx_pkg::*;
#(
  parameter int PW       = 104,
  parameter int LW       = 8,
  parameter int BURST_EN = 1
) (
  input  logic              tx_lclk,
  input  logic              nreset,
  etx_serializer_if.slave   tx,
  input  logic              tx_wr_wait,
  input  logic              tx_rd_wait,
  output logic [2*LW-1:0]   txo_data,
  output logic              txo_frame,
  output logic              tx_busy
);

  localparam int        BW   = 2 * LW;
  localparam beat_cnt_t CNTS = beat_counts(LW);
  localparam logic [3:0] HC_L = CNTS.hc - 4'd1;
  localparam logic [3:0] PC_L = CNTS.pc - 4'd1;
  localparam logic       BURST_ON = (BURST_EN != 0);

  if (LW != 8 && LW != 16) begin : g_bad_lw
    $error("etx_serializer: LW must be 8 or 16");
  end

  // decoded incoming packet
  logic        dec_write_s;
  logic [1:0]  dec_datamode_s;
  logic [4:0]  dec_ctrlmode_s;
  logic [31:0] dec_dstaddr_s;
  logic [31:0] dec_data_s;
  logic [31:0] dec_srcaddr_s;
  emesh_t      pkt_new_s;

  // state
  state_t      state_r;
  state_t      state_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_s;
  emesh_t      pkt_r;
  logic        run_r;

  // combinational controls
  logic        blocked_s;
  logic        ready_s;
  logic        load_s;
  logic        frame_s;
  logic [PAY_W-1:0] word_s;
  logic [3:0]  slice_s;
  logic [BW-1:0] beat_s;

  // registered outputs
  logic [BW-1:0] data_r;
  logic          frame_r;
  logic          busy_r;

  packet2emesh #(.PW(PW)) u_p2e (
    .packet   (tx.tx_packet),
    .write    (dec_write_s),
    .datamode (dec_datamode_s),
    .ctrlmode (dec_ctrlmode_s),
    .dstaddr  (dec_dstaddr_s),
    .data     (dec_data_s),
    .srcaddr  (dec_srcaddr_s)
  );

  assign pkt_new_s = {dec_write_s, dec_datamode_s, dec_ctrlmode_s,
                      dec_dstaddr_s, dec_data_s, dec_srcaddr_s};

  // Next-state, handshake and slice selection for the serializer FSM.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    ready_s   = 1'b0;
    load_s    = 1'b0;
    frame_s   = 1'b0;
    word_s    = {PAY_W{1'b0}};
    slice_s   = 4'd0;
    blocked_s = tx.tx_valid & (dec_write_s ? tx_wr_wait : tx_rd_wait);

    case (state_r)
      ST_IDLE: begin
        // run_r keeps tx_ready low until the first edge after reset release
        ready_s = run_r & ~blocked_s;
        if (ready_s & tx.tx_valid) begin
          load_s  = 1'b1;
          state_s = ST_HDR;
          cnt_s   = 4'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        frame_s = 1'b1;
        word_s  = {{(PAY_W-HDR_W){1'b0}}, hdr_word(pkt_r)};
        slice_s = HC_L - cnt_r;
        if (cnt_r == HC_L) begin
          state_s = ST_PAY;
          cnt_s   = 4'd0;
        end else begin
          cnt_s   = cnt_r + 4'd1;
        end
      end
      ST_PAY: begin
        frame_s = 1'b1;
        word_s  = {pkt_r.data, pkt_r.srcaddr};
        slice_s = PC_L - cnt_r;
        if (cnt_r == PC_L) begin
          // the last beat is the only point a new packet can join a running frame
          ready_s = ~blocked_s;
          cnt_s   = 4'd0;
          if (ready_s & tx.tx_valid) begin
            load_s = 1'b1;
            if (burstable(BURST_ON, pkt_r, pkt_new_s)) begin
              state_s = ST_PAY;
            end else begin
              state_s = ST_GAP;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      ST_GAP: begin
        state_s = ST_HDR;
        cnt_s   = 4'd0;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase

    beat_s = word_s[slice_s*BW +: BW];
  end

  // FSM state, beat counter and latched packet.
  always_ff @(posedge tx_lclk or negedge nreset) begin
    if (!nreset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      pkt_r   <= '0;
      run_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      run_r   <= 1'b1;
      if (load_s) begin
        pkt_r <= pkt_new_s;
      end else begin
        pkt_r <= pkt_r;
      end
    end
  end

  // Output registers: one beat of latency from the FSM to the pads.
  always_ff @(posedge tx_lclk or negedge nreset) begin
    if (!nreset) begin
      data_r  <= {BW{1'b0}};
      frame_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      data_r  <= beat_s;
      frame_r <= frame_s;
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  assign tx.tx_ready = ready_s;
  assign txo_data    = data_r;
  assign txo_frame   = frame_r;
  assign tx_busy     = busy_r;

endmodule

// File: tb/tb_etx_serializer.sv
// Scoreboard bench for etx_serializer: LW=8 and LW=16 instances.
module tb_etx_serializer;

  localparam int PW = 104;

  logic tx_lclk = 1'b0;
  always #5 tx_lclk = ~tx_lclk;

  logic        nreset;
  logic        wr_wait8, rd_wait8, wr_wait16, rd_wait16;
  logic [15:0] data8;
  logic        frame8, busy8;
  logic [31:0] data16;
  logic        frame16, busy16;

  etx_serializer_if #(.PW(PW)) bus8 ();
  etx_serializer_if #(.PW(PW)) bus16 ();

  etx_serializer #(.PW(PW), .LW(8), .BURST_EN(1)) dut8 (
    .tx_lclk(tx_lclk), .nreset(nreset), .tx(bus8),
    .tx_wr_wait(wr_wait8), .tx_rd_wait(rd_wait8),
    .txo_data(data8), .txo_frame(frame8), .tx_busy(busy8)
  );

  etx_serializer #(.PW(PW), .LW(16), .BURST_EN(1)) dut16 (
    .tx_lclk(tx_lclk), .nreset(nreset), .tx(bus16),
    .tx_wr_wait(wr_wait16), .tx_rd_wait(rd_wait16),
    .txo_data(data16), .txo_frame(frame16), .tx_busy(busy16)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] exp8_q[$];
  int          len8_q[$];
  logic [31:0] exp16_q[$];
  int          len16_q[$];
  int run8 = 0, low8 = 0, last_gap8 = 0, run16 = 0;

  function automatic logic [103:0] mk(input logic w, input logic [1:0] dm, input logic [4:0] ctrl,
                                      input logic [31:0] dst, input logic [31:0] dat, input logic [31:0] src);
    return {src, dat, dst, ctrl, dm, w};
  endfunction

  function automatic logic [47:0] hdr(input logic w, input logic [1:0] dm, input logic [3:0] ctrl,
                                      input logic [31:0] dst);
    return {~w, 7'd0, ctrl, dst, dm, w, 1'b1};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push8(input logic [47:0] h, input logic [31:0] dat, input logic [31:0] src, input bit with_hdr);
    if (with_hdr) begin
      exp8_q.push_back(h[47:32]);
      exp8_q.push_back(h[31:16]);
      exp8_q.push_back(h[15:0]);
    end
    exp8_q.push_back(dat[31:16]);
    exp8_q.push_back(dat[15:0]);
    exp8_q.push_back(src[31:16]);
    exp8_q.push_back(src[15:0]);
  endtask

  // LW=8 monitor: every framed beat pops the data scoreboard; each frame end pops the length scoreboard.
  always @(negedge tx_lclk) begin
    if (frame8 === 1'b1) begin
      if (run8 == 0) last_gap8 = low8;
      run8++;
      low8 = 0;
      if (exp8_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL beat8: unexpected beat 0x%0h, expected no frame", data8);
      end else begin
        check("beat8", {48'd0, data8}, {48'd0, exp8_q.pop_front()});
      end
    end else begin
      check("idle_data8", {48'd0, data8}, 64'd0);
      if (run8 > 0) begin
        if (len8_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_len8: frame of %0d cycles, expected none", run8);
        end else begin
          check("frame_len8", 64'(run8), 64'(len8_q.pop_front()));
        end
        run8 = 0;
      end
      low8++;
    end
  end

  // LW=16 monitor.
  always @(negedge tx_lclk) begin
    if (frame16 === 1'b1) begin
      run16++;
      if (exp16_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL beat16: unexpected beat 0x%0h, expected no frame", data16);
      end else begin
        check("beat16", {32'd0, data16}, {32'd0, exp16_q.pop_front()});
      end
    end else if (run16 > 0) begin
      if (len16_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL frame_len16: frame of %0d cycles, expected none", run16);
      end else begin
        check("frame_len16", 64'(run16), 64'(len16_q.pop_front()));
      end
      run16 = 0;
    end
  end

  task automatic send8(input logic [103:0] p);
    bit ok;
    ok = 1'b0;
    bus8.tx_packet = p;
    bus8.tx_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge tx_lclk);
      if (bus8.tx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send8: tx_ready=0 for 100 cycles, expected 1");
    end
    @(posedge tx_lclk);
    #1;
    bus8.tx_valid = 1'b0;
  endtask

  task automatic send16(input logic [103:0] p);
    bit ok;
    ok = 1'b0;
    bus16.tx_packet = p;
    bus16.tx_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge tx_lclk);
      if (bus16.tx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send16: tx_ready=0 for 100 cycles, expected 1");
    end
    @(posedge tx_lclk);
    #1;
    bus16.tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge tx_lclk);
      #1;
      if (exp8_q.size() == 0 && len8_q.size() == 0 && exp16_q.size() == 0 && len16_q.size() == 0
          && busy8 === 1'b0 && busy16 === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: %0d beats still expected after 300 cycles, expected 0", name,
               exp8_q.size() + exp16_q.size());
    end
    repeat (2) @(posedge tx_lclk);
    #1;
  endtask

  initial begin
    nreset = 1'b0;
    wr_wait8 = 1'b0; rd_wait8 = 1'b0; wr_wait16 = 1'b0; rd_wait16 = 1'b0;
    bus8.tx_valid = 1'b0;  bus8.tx_packet = '0;
    bus16.tx_valid = 1'b0; bus16.tx_packet = '0;
    repeat (3) @(posedge tx_lclk);
    #1;
    check("rst_data8",  {48'd0, data8}, 64'd0);
    check("rst_frame8", {63'd0, frame8}, 64'd0);
    check("rst_ready8", {63'd0, bus8.tx_ready}, 64'd0);
    check("rst_busy8",  {63'd0, busy8}, 64'd0);
    check("rst_data16", {32'd0, data16}, 64'd0);
    nreset = 1'b1;
    @(posedge tx_lclk);
    #1;
    check("ready_after_rst", {63'd0, bus8.tx_ready}, 64'd1);

    // single write: header 0x0008_0000_000B, then payload
    len8_q.push_back(7);
    exp8_q.push_back(16'h0008); exp8_q.push_back(16'h0000); exp8_q.push_back(16'h000B);
    exp8_q.push_back(16'h1122); exp8_q.push_back(16'h3344);
    exp8_q.push_back(16'h5566); exp8_q.push_back(16'h7788);
    send8(mk(1'b1, 2'b10, 5'd0, 32'h8000_0000, 32'h1122_3344, 32'h5566_7788));
    check("busy_single", {63'd0, busy8}, 64'd1);
    wait_idle("single");

    // three sequential 64-bit writes merge into one 15-cycle frame
    len8_q.push_back(15);
    push8(hdr(1'b1, 2'b11, 4'd0, 32'h100), 32'hA000_0001, 32'hB000_0001, 1'b1);
    push8(48'd0, 32'hA000_0002, 32'hB000_0002, 1'b0);
    push8(48'd0, 32'hA000_0003, 32'hB000_0003, 1'b0);
    send8(mk(1'b1, 2'b11, 5'd0, 32'h100, 32'hA000_0001, 32'hB000_0001));
    send8(mk(1'b1, 2'b11, 5'd0, 32'h108, 32'hA000_0002, 32'hB000_0002));
    send8(mk(1'b1, 2'b11, 5'd0, 32'h110, 32'hA000_0003, 32'hB000_0003));
    wait_idle("burst3");

    // non-sequential writes: two full frames with a single gap cycle
    len8_q.push_back(7); len8_q.push_back(7);
    push8(hdr(1'b1, 2'b11, 4'd0, 32'h100), 32'h0000_1111, 32'h0000_2222, 1'b1);
    push8(hdr(1'b1, 2'b11, 4'd0, 32'h200), 32'h0000_3333, 32'h0000_4444, 1'b1);
    send8(mk(1'b1, 2'b11, 5'd0, 32'h100, 32'h0000_1111, 32'h0000_2222));
    send8(mk(1'b1, 2'b11, 5'd0, 32'h200, 32'h0000_3333, 32'h0000_4444));
    wait_idle("nonburst");
    check("gap_len", 64'(last_gap8), 64'd1);

    // address wrap 0xFFFFFFF8 -> 0x0 still bursts: 3 + 2*4 cycles
    len8_q.push_back(11);
    push8(hdr(1'b1, 2'b11, 4'd5, 32'hFFFF_FFF8), 32'hDEAD_0001, 32'hBEEF_0001, 1'b1);
    push8(48'd0, 32'hDEAD_0002, 32'hBEEF_0002, 1'b0);
    send8(mk(1'b1, 2'b11, 5'd5, 32'hFFFF_FFF8, 32'hDEAD_0001, 32'hBEEF_0001));
    send8(mk(1'b1, 2'b11, 5'd5, 32'h0000_0000, 32'hDEAD_0002, 32'hBEEF_0002));
    wait_idle("wrap");

    // write wait on the last payload beat breaks a would-be burst
    len8_q.push_back(7); len8_q.push_back(7);
    push8(hdr(1'b1, 2'b11, 4'd0, 32'h300), 32'h0303_0303, 32'h3030_3030, 1'b1);
    push8(hdr(1'b1, 2'b11, 4'd0, 32'h308), 32'h0808_0808, 32'h8080_8080, 1'b1);
    send8(mk(1'b1, 2'b11, 5'd0, 32'h300, 32'h0303_0303, 32'h3030_3030));
    bus8.tx_packet = mk(1'b1, 2'b11, 5'd0, 32'h308, 32'h0808_0808, 32'h8080_8080);
    bus8.tx_valid  = 1'b1;
    repeat (6) @(posedge tx_lclk);
    #1;
    wr_wait8 = 1'b1;
    @(negedge tx_lclk);
    check("ready_last_beat_wait", {63'd0, bus8.tx_ready}, 64'd0);
    @(posedge tx_lclk);
    #1;
    wr_wait8 = 1'b0;
    send8(mk(1'b1, 2'b11, 5'd0, 32'h308, 32'h0808_0808, 32'h8080_8080));
    wait_idle("burst_break");

    // write pushback: blocked write, read goes first, write follows wait release
    len8_q.push_back(7); len8_q.push_back(7);
    push8(hdr(1'b0, 2'b10, 4'd0, 32'h500), 32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b1);
    push8(hdr(1'b1, 2'b10, 4'd0, 32'h400), 32'h0123_4567, 32'h89AB_CDEF, 1'b1);
    wr_wait8 = 1'b1;
    bus8.tx_packet = mk(1'b1, 2'b10, 5'd0, 32'h400, 32'h0123_4567, 32'h89AB_CDEF);
    bus8.tx_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge tx_lclk);
      check("wr_blocked", {63'd0, bus8.tx_ready}, 64'd0);
    end
    @(posedge tx_lclk);
    #1;
    bus8.tx_packet = mk(1'b0, 2'b10, 5'd0, 32'h500, 32'hCAFE_F00D, 32'h0BAD_BEEF);
    @(negedge tx_lclk);
    check("rd_ready", {63'd0, bus8.tx_ready}, 64'd1);
    @(posedge tx_lclk);
    #1;
    bus8.tx_packet = mk(1'b1, 2'b10, 5'd0, 32'h400, 32'h0123_4567, 32'h89AB_CDEF);
    check("rd_accepted", {63'd0, busy8}, 64'd1);
    for (int i = 0; i < 50; i++) begin
      @(negedge tx_lclk);
      if (busy8 === 1'b0) break;
    end
    @(negedge tx_lclk);
    check("wr_blocked_idle", {63'd0, bus8.tx_ready}, 64'd0);
    @(posedge tx_lclk);
    #1;
    wr_wait8 = 1'b0;
    @(negedge tx_lclk);
    check("wr_ready_after_release", {63'd0, bus8.tx_ready}, 64'd1);
    @(posedge tx_lclk);
    #1;
    bus8.tx_valid = 1'b0;
    check("wr_accepted", {63'd0, busy8}, 64'd1);
    wait_idle("pushback");

    // LW=16 single read: header 0x0000_8000_0000_0409 in two 32-bit beats
    len16_q.push_back(4);
    exp16_q.push_back(32'h0000_8000); exp16_q.push_back(32'h0000_0409);
    exp16_q.push_back(32'hAABB_CCDD); exp16_q.push_back(32'h0102_0304);
    send16(mk(1'b0, 2'b10, 5'd0, 32'h0000_0040, 32'hAABB_CCDD, 32'h0102_0304));
    wait_idle("lw16_read");

    // reset mid-payload: 3 header + 2 payload beats seen, then outputs clear at once
    len8_q.push_back(5);
    push8(hdr(1'b1, 2'b10, 4'd0, 32'h600), 32'h6666_0000, 32'h0000_6666, 1'b1);
    void'(exp8_q.pop_back());
    void'(exp8_q.pop_back());
    send8(mk(1'b1, 2'b10, 5'd0, 32'h600, 32'h6666_0000, 32'h0000_6666));
    repeat (6) @(posedge tx_lclk);
    #2;
    nreset = 1'b0;
    #1;
    check("midrst_frame", {63'd0, frame8}, 64'd0);
    check("midrst_data",  {48'd0, data8}, 64'd0);
    check("midrst_busy",  {63'd0, busy8}, 64'd0);
    repeat (2) @(posedge tx_lclk);
    #3;
    nreset = 1'b1;
    len8_q.push_back(7);
    push8(hdr(1'b1, 2'b10, 4'd0, 32'h700), 32'h7777_0000, 32'h0000_7777, 1'b1);
    send8(mk(1'b1, 2'b10, 5'd0, 32'h700, 32'h7777_0000, 32'h0000_7777));
    wait_idle("after_rst");

    check("exp8_empty",  64'(exp8_q.size()), 64'd0);
    check("len8_empty",  64'(len8_q.size()), 64'd0);
    check("exp16_empty", 64'(exp16_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/etx_serializer.md
# etx_serializer

Parametrised eLink transmit serializer: accepts emesh packets on a valid/ready interface, splits each into a header phase and a payload phase, and emits 2×LW bits per clock with a frame strobe. It supports link widths of 8 or 16, honours write/read pushback, and merges sequential 64-bit writes into bursts. It sits between the etx arbiter and the ODDR/OBUFDS pad layer, which consumes txo_data and txo_frame unchanged.

## Interface
- PW, 104: emesh packet width.
- LW, 8: link width per DDR edge; legal values 8 or 16.
- BURST_EN, 1: 1 enables burst merging; 0 frames every packet.
- tx_lclk  in  1  fast link clock; the only clock.
- nreset  in  1  asynchronous, active-low reset.
- tx_packet  in  PW  emesh packet, decoded by packet2emesh.
- tx_valid  in  1  packet valid.
- tx_ready  out  1  packet accepted on tx_valid&tx_ready at a rising edge.
- tx_wr_wait  in  1  write pushback, already synchronised to tx_lclk.
- tx_rd_wait  in  1  read pushback, already synchronised to tx_lclk.
- txo_data  out  2×LW  beat pair; the upper LW bits go on the rising edge.
- txo_frame  out  1  frame strobe; identical on both edges.
- tx_busy  out  1  high whenever the state is not IDLE.

## Operation
- Header word H[47:0] is {~write, 7'b0, ctrlmode[3:0], dstaddr[31:0], datamode[1:0], write, access}.
- Payload word P[63:0] is {data[31:0], srcaddr[31:0]}.
- HC is the number of header cycles: 3 for LW=8, 2 for LW=16. For LW=16 the header is zero-extended to 64 bits.
- PC is the number of payload cycles: 4 for LW=8, 2 for LW=16.
- Each word is sent most-significant slice first.
- Blocked: a packet with write=1 and tx_wr_wait=1, or write=0 and tx_rd_wait=1, is blocked. tx_ready is 0 while a blocked packet is presented.
- States: IDLE, HDR, PAY, GAP. A beat counter counts from 0 to HC-1 in HDR and from 0 to PC-1 in PAY.
- IDLE: tx_ready = ~blocked. On accept, latch the packet and go to HDR.
- HDR: on the last header beat, go to PAY.
- PAY, not the last beat: tx_ready=0.
- PAY, last beat: tx_ready = ~blocked. Next state:
  - no accept: IDLE;
  - accept and burstable: PAY with the counter at 0, header skipped, txo_frame held high;
  - accept and not burstable: GAP.
- Burstable means BURST_EN=1 and all of the following, comparing the new packet with the previous one:
  - both packets have write=1 and datamode=2'b11;
  - ctrlmode is equal;
  - new dstaddr equals previous dstaddr + 8, modulo 2^32.
- GAP: txo_frame=0 and txo_data=0 for exactly one cycle, then HDR with the latched packet.
- Pushback never truncates a frame that has started. Wait changes affect only acceptance.
- If a wait asserts in the same cycle as the last payload beat, the burst breaks and the packet is not accepted.

## Timing
- Reset values: txo_data=0, txo_frame=0, tx_ready=0, tx_busy=0, state IDLE. tx_ready may rise in the first cycle after nreset deasserts.
- Latency: a packet accepted at edge N produces its first header beat at edge N+1, with txo_frame=1 aligned to that beat. All outputs are registered except tx_ready.
- Single packet: txo_frame stays high for HC+PC cycles, 7 for LW=8.
- Back-to-back non-burst packets: frame high, one low cycle, frame high again.
- A burst of k packets holds txo_frame high for HC + k×PC cycles.
- nreset asserted mid-frame: all outputs go to reset values immediately (asynchronous). The packet in flight is dropped.
- dstaddr wrapping from 0xFFFFFFF8 to 0x00000000 still counts as burstable.

## Structure
- Package etx_pkg holds:
  - state encoding;
  - HDR_W=48 and PAY_W=64;
  - a function returning HC and PC for a given LW;
  - the burstable predicate as a function.
- Reuse packet2emesh for field decode. No other sub-module is needed; the serializer is a single module with a slice mux indexed by state and counter.
- The elaboration check rejects LW values other than 8 or 16.

## Test plan
- Single write, LW=8, dstaddr=0x80000000, data=0x11223344, srcaddr=0x55667788: 7 framed cycles, header then payload.
  - txo_data in beats 4–7: 0x1122, 0x3344, 0x5566, 0x7788.
  - txo_frame is 0 in the cycle after beat 7.
- Three 64-bit writes at 0x100, 0x108, 0x110, presented back to back: txo_frame high for 3+12=15 cycles, with only one header.
- Write to 0x100, then write to 0x200: frame, one GAP cycle with frame=0, then a second full 7-cycle frame.
- tx_wr_wait=1 with a write presented and a read presented afterwards, tx_rd_wait=0:
  - tx_ready=0 for the write; the write is not accepted.
  - The read is accepted as soon as it is presented. The write is accepted one cycle after tx_wr_wait falls.
- LW=16 single read: HC=2, PC=2, so 4 framed cycles. The first beat's upper 16 bits are 0.
- nreset pulsed low in payload beat 2: txo_frame=0 and txo_data=0 immediately. The next packet after release starts cleanly with a header.
